i2c_master_ctrl: RTL and testbench

//  Single-master I2C byte engine feeding i2c_slave_memory from the AXI side of the bridge.

---
 rtl/i2c_master_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl - single-master I2C byte engine.
// Takes one register-access command (write: dev/reg/wdata, read: dev/reg then
// repeated START and one data byte), drives SCL push-pull and SDA open-drain
// style, and returns read data plus a NACK error flag.
//
// Parameter: CLK_DIV - ACLK cycles per SCL quarter period (>= 2).
// Optional feature macro: I2C_MASTER_CLK_STRETCH_EN - when defined, the
//   quarter counter freezes in the third quarter while scl_i is low.
//
// Ports:
//   ACLK, RESETn            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_rw/dev_id/reg/wdata command fields (latched at accept)
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata/rsp_err       read byte, NACK flag
//   busy                    accept .. response handshake
//   scl_o/scl_i             SCL drive / observed bus level
//   m_sda_o/_en/m_sda_i     SDA drive value, drive enable, bus level
module i2c_master_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       ACLK,
  input  logic       RESETn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev_id,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  output logic       scl_o,
  input  logic       scl_i,
  output logic       m_sda_o,
  output logic       m_sda_o_en,
  input  logic       m_sda_i
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("i2c_master_ctrl: CLK_DIV must be >= 2");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_TX, S_ACK_RX, S_RSTART, S_RX, S_ACK_TX, S_STOP, S_RESP
  } state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_q;
  logic [2:0]      r_bit;
  logic [1:0]      r_phase;   // 0: dev byte, 1: reg byte, 2: wdata / read dev byte
  logic [7:0]      r_sh;
  logic            r_ack;
  logic            r_rw;
  logic [6:0]      r_dev;
  logic [7:0]      r_reg;
  logic [7:0]      r_wdata;
  logic [7:0]      r_rdata;
  logic            r_err;

  logic w_run, w_freeze, w_qend, w_sample, w_slot_end, w_accept;

  assign w_run    = (r_state != S_IDLE) && (r_state != S_RESP);
  assign w_accept = cmd_valid && (r_state == S_IDLE);

`ifdef I2C_MASTER_CLK_STRETCH_EN
  assign w_freeze = (r_q == 2'd2) && !scl_i;
`else
  logic w_unused_scl_i;
  assign w_unused_scl_i = scl_i;
  assign w_freeze = 1'b0;
`endif

  assign w_qend     = w_run && !w_freeze && (r_cnt == CNT_MAX);
  assign w_sample   = w_qend && (r_q == 2'd2);
  assign w_slot_end = w_qend && (r_q == 2'd3);

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  always_ff @(posedge ACLK or negedge RESETn) begin
    if (!RESETn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    scl_o      = 1'b1;
    m_sda_o    = 1'b1;
    m_sda_o_en = 1'b0;
    case (r_state)
      S_IDLE: if (cmd_valid) w_next = S_START;
      S_START: begin
        m_sda_o_en = 1'b1;
        m_sda_o    = (r_q == 2'd0);
        if (w_slot_end) w_next = S_TX;
      end
      S_TX: begin
        scl_o      = r_q[1];
        m_sda_o_en = 1'b1;
        m_sda_o    = r_sh[7];
        if (w_slot_end && r_bit == 3'd0) w_next = S_ACK_RX;
      end
      S_ACK_RX: begin
        scl_o = r_q[1];
        if (w_slot_end) begin
          if (r_ack) w_next = S_STOP;
          else begin
            case (r_phase)
              2'd0:    w_next = S_TX;
              2'd1:    w_next = r_rw ? S_RSTART : S_TX;
              default: w_next = r_rw ? S_RX : S_STOP;
            endcase
          end
        end
      end
      S_RSTART: begin
        // low/high/high/low SCL so SDA can fall while SCL is high in q2
        scl_o      = (r_q == 2'd1) || (r_q == 2'd2);
        m_sda_o_en = 1'b1;
        m_sda_o    = !r_q[1];
        if (w_slot_end) w_next = S_TX;
      end
      S_RX: begin
        scl_o = r_q[1];
        if (w_slot_end && r_bit == 3'd0) w_next = S_ACK_TX;
      end
      S_ACK_TX: begin
        scl_o      = r_q[1];
        m_sda_o_en = 1'b1;
        if (w_slot_end) w_next = S_STOP;
      end
      S_STOP: begin
        scl_o      = (r_q != 2'd0);
        m_sda_o_en = 1'b1;
        m_sda_o    = r_q[1];
        if (w_slot_end) w_next = S_RESP;
      end
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge RESETn) begin
    if (!RESETn) begin
      r_cnt   <= '0;
      r_q     <= '0;
      r_bit   <= '0;
      r_phase <= '0;
      r_sh    <= '0;
      r_ack   <= 1'b0;
      r_rw    <= 1'b0;
      r_dev   <= '0;
      r_reg   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (!w_run) begin
        r_cnt <= '0;
        r_q   <= '0;
      end else if (!w_freeze) begin
        r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
        if (w_qend) r_q <= r_q + 2'd1;
      end

      if (w_accept) begin
        r_rw    <= cmd_rw;
        r_dev   <= cmd_dev_id;
        r_reg   <= cmd_reg;
        r_wdata <= cmd_wdata;
        r_sh    <= {cmd_dev_id, 1'b0};
        r_bit   <= 3'd7;
        r_phase <= 2'd0;
        r_rdata <= '0;
        r_err   <= 1'b0;
      end

      case (r_state)
        S_TX: if (w_slot_end) begin
          r_sh  <= {r_sh[6:0], 1'b0};
          r_bit <= r_bit - 3'd1;   // wraps to 7, ready for the next byte
        end
        S_ACK_RX: begin
          if (w_sample) r_ack <= m_sda_i;
          if (w_slot_end) begin
            if (r_ack) r_err <= 1'b1;
            else begin
              case (r_phase)
                2'd0: begin
                  r_sh    <= r_reg;
                  r_phase <= 2'd1;
                end
                2'd1: begin
                  r_sh    <= r_rw ? {r_dev, 1'b1} : r_wdata;
                  r_phase <= 2'd2;
                end
                default: ;
              endcase
            end
          end
        end
        S_RX: begin
          if (w_sample) r_sh <= {r_sh[6:0], m_sda_i};
          if (w_slot_end) begin
            r_bit <= r_bit - 3'd1;
            if (r_bit == 3'd0) r_rdata <= r_sh;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
module tb_i2c_master_ctrl;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned SLOT    = 4 * CLK_DIV;
  localparam logic [6:0]  SLV_ID  = 7'h01;
  localparam int unsigned STRETCH = 20;

  logic       ACLK = 1'b0;
  logic       RESETn = 1'b0;
  logic       cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic [6:0] cmd_dev_id = '0;
  logic [7:0] cmd_reg = '0, cmd_wdata = '0;
  logic       rsp_ready = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_err, busy;
  logic [7:0] rsp_rdata;
  logic       scl_o, scl_i, m_sda_o, m_sda_o_en, m_sda_i;

  logic slv_drive = 1'b0;
  logic stretch_hold = 1'b0;

  assign scl_i   = scl_o & ~stretch_hold;
  assign m_sda_i = (m_sda_o_en ? m_sda_o : 1'b1) & ~slv_drive;

  always #5 ACLK = ~ACLK;

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .ACLK(ACLK), .RESETn(RESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev_id(cmd_dev_id), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .scl_o(scl_o), .scl_i(scl_i),
    .m_sda_o(m_sda_o), .m_sda_o_en(m_sda_o_en), .m_sda_i(m_sda_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural slave + bus log
  logic [7:0] slv_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] log_bytes [$];
  int         log_starts, log_stops;
  logic       log_mack;
  int         s_orise, stretch_at;

  initial begin
    logic       p_scl, p_sda, p_oscl, scl_now, sda_now;
    logic [7:0] s_sh, s_txbyte, s_ptr;
    int         s_cnt, s_nbytes, st_left;
    bit         s_addressed, s_tx;
    p_scl = 1'b1; p_sda = 1'b1; p_oscl = 1'b1;
    s_sh = '0; s_txbyte = '0; s_ptr = '0;
    s_cnt = 0; s_nbytes = 0; st_left = 0;
    s_addressed = 0; s_tx = 0;
    forever begin
      @(negedge ACLK);
      if (!RESETn) begin
        slv_drive = 1'b0; stretch_hold = 1'b0;
        s_cnt = 0; s_nbytes = 0; s_addressed = 0; s_tx = 0;
        p_scl = 1'b1; p_sda = 1'b1; p_oscl = 1'b1;
        continue;
      end
      if (!p_oscl && scl_o) begin
        s_orise++;
        if (stretch_at != 0 && s_orise == stretch_at) begin
          stretch_hold = 1'b1;
          st_left = STRETCH;
        end
      end else if (stretch_hold) begin
        st_left--;
        if (st_left == 0) stretch_hold = 1'b0;
      end
      p_oscl  = scl_o;
      scl_now = scl_o & ~stretch_hold;
      sda_now = (m_sda_o_en ? m_sda_o : 1'b1) & ~slv_drive;
      if (p_scl && scl_now && p_sda && !sda_now) begin
        log_starts++;
        s_cnt = 0; s_nbytes = 0; s_tx = 0; s_addressed = 0; slv_drive = 1'b0;
      end else if (p_scl && scl_now && !p_sda && sda_now) begin
        log_stops++;
        s_cnt = 0; s_tx = 0; s_addressed = 0; slv_drive = 1'b0;
      end else if (!p_scl && scl_now) begin
        if (s_cnt < 8) begin
          s_sh = {s_sh[6:0], sda_now};
          s_cnt++;
          if (s_cnt == 8) begin
            log_bytes.push_back(s_sh);
            s_nbytes++;
            if (s_nbytes == 1) begin
              s_addressed = (s_sh[7:1] == SLV_ID);
              s_tx = s_addressed && s_sh[0];
              if (s_tx) s_txbyte = slv_mem[s_ptr];
            end else if (s_addressed && !s_tx) begin
              if (s_nbytes == 2) s_ptr = s_sh;
              else slv_mem[s_ptr] = s_sh;
            end
          end
        end else begin
          log_mack = sda_now;
          s_cnt = 0;
          if (s_tx && sda_now) s_tx = 0;
        end
      end else if (p_scl && !scl_now) begin
        if (s_cnt == 8) slv_drive = s_addressed && (s_nbytes == 1 || !s_tx);
        else if (s_tx) slv_drive = ~s_txbyte[7 - s_cnt];
        else slv_drive = 1'b0;
      end
      p_scl = scl_now;
      p_sda = (m_sda_o_en ? m_sda_o : 1'b1) & ~slv_drive;
    end
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    ok = 1;
    @(negedge ACLK);
    while (!cmd_ready && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 32'(cmd_ready), 32'd1);
      ok = 0;
    end
  endtask

  task automatic run_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input int unsigned delay,
                         input bit stall_cmd, input int st_at);
    logic [7:0]  exp_bytes [$];
    logic [7:0]  exp_rdata, hold_rdata;
    logic        exp_err, hold_err;
    int unsigned exp_cyc, cyc, viol;
    bit          ok;
    // reference model from the transaction rules
    exp_bytes.delete();
    exp_bytes.push_back({dev, 1'b0});
    exp_rdata = 8'h00;
    exp_err   = 1'b0;
    if (dev != SLV_ID) begin
      exp_err = 1'b1;
      exp_cyc = 11 * SLOT;
    end else if (!rw) begin
      exp_bytes.push_back(rg);
      exp_bytes.push_back(wd);
      exp_cyc = 29 * SLOT;
      ref_mem[rg] = wd;
    end else begin
      exp_bytes.push_back(rg);
      exp_bytes.push_back({dev, 1'b1});
      exp_bytes.push_back(ref_mem[rg]);
      exp_rdata = ref_mem[rg];
      exp_cyc = 39 * SLOT;
    end
`ifdef I2C_MASTER_CLK_STRETCH_EN
    if (st_at != 0) exp_cyc += STRETCH;
`endif

    wait_ready(ok);
    if (!ok) return;
    log_bytes.delete();
    log_starts = 0; log_stops = 0; log_mack = 1'b0;
    s_orise = 0; stretch_at = st_at;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_dev_id = dev; cmd_reg = rg; cmd_wdata = wd;
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
    cmd_rw = ~rw; cmd_dev_id = 7'($urandom); cmd_reg = 8'($urandom); cmd_wdata = 8'($urandom);
    check("accept_busy", {busy, cmd_ready, rsp_valid}, 3'b100);
    check("accept_rdata_clr", 32'(rsp_rdata), 32'h00);

    cyc = 0;
    while (!rsp_valid && cyc < 3000) begin
      @(posedge ACLK); #1;
      cyc++;
    end
    check("latency", cyc, exp_cyc);
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("bus_idle", {scl_o, m_sda_o_en}, 2'b10);
    check("nbytes", 32'(log_bytes.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < log_bytes.size(); i++)
      check($sformatf("byte%0d", i), 32'(log_bytes[i]), 32'(exp_bytes[i]));
    check("starts", 32'(log_starts), (rw && !exp_err) ? 32'd2 : 32'd1);
    check("stops", 32'(log_stops), 32'd1);
    if (rw && !exp_err) check("master_nack", 32'(log_mack), 32'd1);

    hold_rdata = rsp_rdata;
    hold_err   = rsp_err;
    viol = 0;
    for (int unsigned i = 0; i < delay; i++) begin
      if (stall_cmd) begin
        cmd_valid = 1'b1; cmd_rw = 1'($urandom);
        cmd_dev_id = SLV_ID; cmd_reg = 8'($urandom); cmd_wdata = 8'($urandom);
      end
      @(posedge ACLK); #1;
      if (!rsp_valid || cmd_ready || !busy || rsp_rdata !== hold_rdata ||
          rsp_err !== hold_err || !scl_o || m_sda_o_en) viol++;
    end
    if (delay > 0) check("stall_hold", viol, 32'd0);
    rsp_ready = 1'b1;
    @(posedge ACLK); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("post_handshake", {cmd_ready, busy, rsp_valid}, 3'b100);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int unsigned cyc;
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = 8'($urandom);
      ref_mem[i] = slv_mem[i];
    end
    s_orise = 0; stretch_at = 0; log_starts = 0; log_stops = 0; log_mack = 1'b0;

    repeat (3) @(posedge ACLK);
    #1;
    check("reset_vals",
          {scl_o, m_sda_o, m_sda_o_en, cmd_ready, rsp_valid, busy, rsp_err, rsp_rdata},
          {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge ACLK); RESETn = 1'b1;

    run_cmd(1'b0, 7'h01, 8'h10, 8'hA5, 0, 0, 0);
    slv_mem[8'h10] = 8'h5A; ref_mem[8'h10] = 8'h5A;
    run_cmd(1'b1, 7'h01, 8'h10, 8'h00, 0, 0, 0);
    run_cmd(1'b0, 7'h22, 8'h10, 8'h77, 0, 0, 0);
    run_cmd(1'b0, 7'h01, 8'h33, 8'hC3, 50, 1, 0);

    // abort a write during bit 3 of the register byte
    wait_ready(ok);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_dev_id = SLV_ID; cmd_reg = 8'h33; cmd_wdata = 8'h99;
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
    cyc = 0;
    while (cyc < 14 * SLOT + 6) begin
      @(posedge ACLK); #1;
      cyc++;
    end
    #2 RESETn = 1'b0;
    #1;
    check("abort_reset_vals",
          {scl_o, m_sda_o, m_sda_o_en, cmd_ready, rsp_valid, busy, rsp_err, rsp_rdata},
          {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    repeat (2) @(posedge ACLK);
    @(negedge ACLK); RESETn = 1'b1;
    run_cmd(1'b1, 7'h01, 8'h33, 8'h00, 0, 0, 0);

`ifdef I2C_MASTER_CLK_STRETCH_EN
    run_cmd(1'b0, 7'h01, 8'h44, 8'h3C, 0, 0, 26);
    run_cmd(1'b1, 7'h01, 8'h44, 8'h00, 0, 0, 0);
`endif

    for (int i = 0; i < 16; i++) begin
      logic [6:0] dev;
      dev = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(2, 127)) : SLV_ID;
      run_cmd(1'($urandom), dev, 8'($urandom_range(0, 15)), 8'($urandom),
              $urandom_range(0, 5), 1'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
